// File: rtl/fault_inj_pkg.sv
// Shared encodings, FSM state constants and size defaults for the fault injector.
package fault_inj_pkg;

   localparam int LANES_DEFAULT = 8;
   localparam int WIDTH_DEFAULT = 32;

   typedef logic [1:0] kind_t;
   localparam kind_t KIND_SA0  = 2'b00;
   localparam kind_t KIND_SA1  = 2'b01;
   localparam kind_t KIND_FLIP = 2'b10;
   localparam kind_t KIND_RSVD = 2'b11;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_WAIT   = 2'd1;
   localparam state_t ST_ACTIVE = 2'd2;

   // Command fields kept after the delay is loaded into the shared counter.
   typedef struct packed {
      logic [2:0] lane;
      logic [4:0] bit_idx;
      kind_t      kind;
      logic [7:0] duration;
   } cmd_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/fi_onehot.sv
// Decodes a (lane, bit) pair into a one-hot vector over the packed lane results.
module fi_onehot #(
   parameter int LANES = 8,
   parameter int WIDTH = 32
) (
   input  logic [2:0]             lane_i,
   input  logic [4:0]             bit_i,
   output logic [LANES*WIDTH-1:0] onehot_o
);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
         assign onehot_o[l*WIDTH + b] = (lane_i == 3'(l)) && (bit_i == 5'(b));
      end
   end

endmodule

// File: rtl/fault_injector.sv
// Fault injector: schedules one stuck-at/flip fault at a time onto redundant ALU lane results.
// Build option FAULT_INJ_ZERO_EN adds the per-lane zero_flip output fed by bit-31 flip commands.
module fault_injector
   import fault_inj_pkg::*;
#(
   parameter int LANES = LANES_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2:0]             cmd_lane,
   input  logic [4:0]             cmd_bit,
   input  logic [1:0]             cmd_kind,
   input  logic [7:0]             cmd_delay,
   input  logic [7:0]             cmd_duration,
   input  logic                   clear_all,
   output logic [LANES*WIDTH-1:0] clr_mask,
   output logic [LANES*WIDTH-1:0] set_mask,
   output logic [LANES*WIDTH-1:0] flip_mask,
`ifdef FAULT_INJ_ZERO_EN
   output logic [LANES-1:0]       zero_flip,
`endif
   output logic                   done,
   output logic                   err,
   output logic [7:0]             inj_count
);

   localparam int MW = LANES*WIDTH;

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   cmd_t          cmd_q, cmd_d;
   logic [MW-1:0] stk_clr_q, stk_clr_d, stk_set_q, stk_set_d, stk_flip_q, stk_flip_d;
   logic [MW-1:0] trn_clr_q, trn_clr_d, trn_set_q, trn_set_d, trn_flip_q, trn_flip_d;
   logic [MW-1:0] clr_q, set_q, flip_q;
   logic          done_q, done_d, err_q, err_d;
   logic [7:0]    inj_q, inj_d;

   logic [MW-1:0] hit, hit_clr, hit_set, hit_flip;
   logic          cmd_bad;

   fi_onehot #(
      .LANES (LANES),
      .WIDTH (WIDTH)
   ) u_onehot (
      .lane_i   (cmd_q.lane),
      .bit_i    (cmd_q.bit_idx),
      .onehot_o (hit)
   );

   assign cmd_ready = (state_q == ST_IDLE) && !clear_all;
   assign cmd_bad   = (cmd_kind == KIND_RSVD) || (32'(cmd_lane) >= LANES);
   assign hit_clr   = (cmd_q.kind == KIND_SA0) ? hit : '0;
   assign hit_set   = (cmd_q.kind == KIND_SA1) ? hit : '0;

`ifdef FAULT_INJ_ZERO_EN
   logic [LANES-1:0] stk_zero_q, stk_zero_d, trn_zero_q, trn_zero_d, zero_q, hit_zero;
   logic             zero_sel;

   // A flip of bit 31 is redirected to the lane's zero_flip line instead of the result bit.
   assign zero_sel  = (cmd_q.bit_idx == 5'd31) && (cmd_q.kind == KIND_FLIP);
   assign hit_zero  = zero_sel ? (LANES'(1) << cmd_q.lane) : '0;
   assign hit_flip  = (cmd_q.kind == KIND_FLIP && !zero_sel) ? hit : '0;
   assign zero_flip = zero_q;
`else
   assign hit_flip  = (cmd_q.kind == KIND_FLIP) ? hit : '0;
`endif

   always_comb begin
      // NOTE: every next-state variable takes its held value first, so no path infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      stk_clr_d  = stk_clr_q;
      stk_set_d  = stk_set_q;
      stk_flip_d = stk_flip_q;
      trn_clr_d  = trn_clr_q;
      trn_set_d  = trn_set_q;
      trn_flip_d = trn_flip_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      inj_d      = inj_q;
`ifdef FAULT_INJ_ZERO_EN
      stk_zero_d = stk_zero_q;
      trn_zero_d = trn_zero_q;
`endif

      if (clear_all) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         stk_clr_d  = '0;
         stk_set_d  = '0;
         stk_flip_d = '0;
         trn_clr_d  = '0;
         trn_set_d  = '0;
         trn_flip_d = '0;
`ifdef FAULT_INJ_ZERO_EN
         stk_zero_d = '0;
         trn_zero_d = '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_bad) begin
                     err_d = 1'b1;
                  end else begin
                     cmd_d.lane     = cmd_lane;
                     cmd_d.bit_idx  = cmd_bit;
                     cmd_d.kind     = cmd_kind;
                     cmd_d.duration = cmd_duration;
                     cnt_d          = cmd_delay;
                     state_d        = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 8'd0) begin
                  inj_d = sat_inc8(inj_q);
                  if (cmd_q.duration == 8'd0) begin
                     stk_clr_d  = stk_clr_q  | hit_clr;
                     stk_set_d  = stk_set_q  | hit_set;
                     stk_flip_d = stk_flip_q | hit_flip;
`ifdef FAULT_INJ_ZERO_EN
                     stk_zero_d = stk_zero_q | hit_zero;
`endif
                     state_d    = ST_IDLE;
                     done_d     = 1'b1;
                  end else begin
                     trn_clr_d  = hit_clr;
                     trn_set_d  = hit_set;
                     trn_flip_d = hit_flip;
`ifdef FAULT_INJ_ZERO_EN
                     trn_zero_d = hit_zero;
`endif
                     cnt_d      = cmd_q.duration;
                     state_d    = ST_ACTIVE;
                  end
               end else if (tick) begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_ACTIVE: begin
               if (cnt_q == 8'd0) begin
                  trn_clr_d  = '0;
                  trn_set_d  = '0;
                  trn_flip_d = '0;
`ifdef FAULT_INJ_ZERO_EN
                  trn_zero_d = '0;
`endif
                  state_d    = ST_IDLE;
                  done_d     = 1'b1;
               end else if (tick) begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cmd_q      <= '0;
         stk_clr_q  <= '0;
         stk_set_q  <= '0;
         stk_flip_q <= '0;
         trn_clr_q  <= '0;
         trn_set_q  <= '0;
         trn_flip_q <= '0;
         clr_q      <= '0;
         set_q      <= '0;
         flip_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         inj_q      <= '0;
`ifdef FAULT_INJ_ZERO_EN
         stk_zero_q <= '0;
         trn_zero_q <= '0;
         zero_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         stk_clr_q  <= stk_clr_d;
         stk_set_q  <= stk_set_d;
         stk_flip_q <= stk_flip_d;
         trn_clr_q  <= trn_clr_d;
         trn_set_q  <= trn_set_d;
         trn_flip_q <= trn_flip_d;
         // Output masks register the combined next value so they change on the same edge as the FSM.
         clr_q      <= stk_clr_d  | trn_clr_d;
         set_q      <= stk_set_d  | trn_set_d;
         flip_q     <= stk_flip_d | trn_flip_d;
         done_q     <= done_d;
         err_q      <= err_d;
         inj_q      <= inj_d;
`ifdef FAULT_INJ_ZERO_EN
         stk_zero_q <= stk_zero_d;
         trn_zero_q <= trn_zero_d;
         zero_q     <= stk_zero_d | trn_zero_d;
`endif
      end
   end

   assign clr_mask  = clr_q;
   assign set_mask  = set_q;
   assign flip_mask = flip_q;
   assign done      = done_q;
   assign err       = err_q;
   assign inj_count = inj_q;

endmodule

// File: tb/tb_fault_injector.sv
// Bench for fault_injector: directed commands queue their expected done/err events and a
// separate monitor compares each event (kind, masks, inj_count) as the DUT presents it.
`timescale 1ns/1ps
module tb_fault_injector;
   import fault_inj_pkg::*;

   localparam int LANES = 8;
   localparam int WIDTH = 32;
   localparam int MW    = LANES*WIDTH;

   logic          clk = 1'b0;
   logic          reset, tick, cmd_valid, cmd_ready, clear_all;
   logic [2:0]    cmd_lane;
   logic [4:0]    cmd_bit;
   logic [1:0]    cmd_kind;
   logic [7:0]    cmd_delay, cmd_duration;
   logic [MW-1:0] clr_mask, set_mask, flip_mask;
   logic          done, err;
   logic [7:0]    inj_count;
`ifdef FAULT_INJ_ZERO_EN
   logic [LANES-1:0] zero_flip;
`endif

   always #5 clk = ~clk;

   fault_injector #(.LANES(LANES), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_lane     (cmd_lane),
      .cmd_bit      (cmd_bit),
      .cmd_kind     (cmd_kind),
      .cmd_delay    (cmd_delay),
      .cmd_duration (cmd_duration),
      .clear_all    (clear_all),
      .clr_mask     (clr_mask),
      .set_mask     (set_mask),
      .flip_mask    (flip_mask),
`ifdef FAULT_INJ_ZERO_EN
      .zero_flip    (zero_flip),
`endif
      .done         (done),
      .err          (err),
      .inj_count    (inj_count)
   );

   typedef struct {
      bit            is_done;
      logic [7:0]    inj;
      logic [MW-1:0] clr;
      logic [MW-1:0] set;
      logic [MW-1:0] flip;
   } exp_t;

   exp_t          sb[$];
   int            vectors = 0;
   int            miscompares = 0;
   logic [MW-1:0] m_clr = '0, m_set = '0, m_flip = '0;
   logic [7:0]    m_inj = '0;

   task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h required %h", name, $time, got, exp);
      end
   endtask

   task automatic expect_event(input bit is_done);
      exp_t e;
      e.is_done = is_done;
      e.inj     = m_inj;
      e.clr     = m_clr;
      e.set     = m_set;
      e.flip    = m_flip;
      sb.push_back(e);
   endtask

   task automatic cycle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offers a command and returns 1 ns after the accepting edge.
   task automatic send(input logic [2:0] lane, input logic [4:0] b, input logic [1:0] kind,
                       input logic [7:0] dly, input logic [7:0] dur);
      int waited;
      waited       = 0;
      cmd_lane     = lane;
      cmd_bit      = b;
      cmd_kind     = kind;
      cmd_delay    = dly;
      cmd_duration = dur;
      cmd_valid    = 1'b1;
      while (!cmd_ready && waited < 64) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!cmd_ready) check("cmd_ready_timeout", MW'(cmd_ready), MW'(1));
      else begin
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 300) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check(name, MW'(sb.size()), MW'(0));
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (done || err) begin
         if (sb.size() == 0) begin
            check("unexpected_event", MW'({done, err}), MW'(0));
         end else begin
            e = sb.pop_front();
            check("event_kind", MW'({done, err}), e.is_done ? MW'(2'b10) : MW'(2'b01));
            check("event_inj", MW'(inj_count), MW'(e.inj));
            check("event_clr", clr_mask, e.clr);
            check("event_set", set_mask, e.set);
            check("event_flip", flip_mask, e.flip);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; tick = 1'b1; cmd_valid = 1'b0; clear_all = 1'b0;
      cmd_lane = '0; cmd_bit = '0; cmd_kind = '0; cmd_delay = '0; cmd_duration = '0;
      cycle(3);
      @(negedge clk);
      check("rst_clr", clr_mask, '0);
      check("rst_set", set_mask, '0);
      check("rst_flip", flip_mask, '0);
      check("rst_inj", MW'(inj_count), MW'(0));
      check("rst_done_err", MW'({done, err}), MW'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", MW'(cmd_ready), MW'(1));

      // Permanent stuck-at-1, lane 3 bit 5 -> set_mask bit 101 one edge after accept.
      m_set[3*WIDTH+5] = 1'b1; m_inj = 8'd1; expect_event(1'b1);
      send(3'd3, 5'd5, KIND_SA1, 8'd0, 8'd0);
      @(negedge clk);
      check("sa1_before", MW'(set_mask[101]), MW'(0));
      @(negedge clk);
      check("sa1_after", set_mask, m_set);
      cycle(4);
      check("sa1_persist", set_mask, m_set);
      check("sa1_inj", MW'(inj_count), MW'(1));
      drain("sa1_drain");

      // Transient flip, delay 2, duration 3: visible 4 cycles starting after accept edge +3.
      m_inj = 8'd2; expect_event(1'b1);
      send(3'd0, 5'd0, KIND_FLIP, 8'd2, 8'd3);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("flip_win%0d", i), MW'(flip_mask[0]), MW'((i >= 3 && i <= 6) ? 1 : 0));
         if (i == 3) check("flip_inj", MW'(inj_count), MW'(2));
      end
      drain("flip_drain");

      // Reserved kind: one err pulse, nothing applied.
      expect_event(1'b0);
      send(3'd1, 5'd2, KIND_RSVD, 8'd5, 8'd5);
      @(negedge clk);
      check("rsvd_ready", MW'(cmd_ready), MW'(1));
      @(negedge clk);
      check("rsvd_err_once", MW'(err), MW'(0));
      drain("rsvd_drain");

      // Delay only counts on ticks; top bit of the last lane, stuck-at-0.
      @(posedge clk); #1;
      tick = 1'b0;
      m_clr[MW-1] = 1'b1; m_inj = 8'd3; expect_event(1'b1);
      send(3'd7, 5'd31, KIND_SA0, 8'd1, 8'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold_wait%0d", i), MW'(clr_mask[MW-1]), MW'(0));
      end
      @(posedge clk); #1;
      tick = 1'b1;
      @(negedge clk);
      check("tick_dec", MW'(clr_mask[MW-1]), MW'(0));
      @(negedge clk);
      check("tick_zero", MW'(clr_mask[MW-1]), MW'(0));
      @(negedge clk);
      check("tick_apply", clr_mask, m_clr);
      drain("tick_drain");

      // clear_all during ACTIVE with sticky bits present: masks drop, no done.
      m_inj = 8'd4;
      send(3'd2, 5'd7, KIND_SA1, 8'd0, 8'd10);
      @(negedge clk);
      @(negedge clk);
      check("act_set71", MW'(set_mask[2*WIDTH+7]), MW'(1));
      check("act_set101", MW'(set_mask[101]), MW'(1));
      @(posedge clk); #1;
      clear_all = 1'b1;
      @(negedge clk);
      check("clr_ready_low", MW'(cmd_ready), MW'(0));
      @(posedge clk); #1;
      clear_all = 1'b0;
      m_clr = '0; m_set = '0; m_flip = '0;
      @(negedge clk);
      check("clr_clr", clr_mask, '0);
      check("clr_set", set_mask, '0);
      check("clr_flip", flip_mask, '0);
      check("clr_inj", MW'(inj_count), MW'(m_inj));
      cycle(15);

      // clear_all wins over a simultaneous accept.
      clear_all = 1'b1;
      cmd_lane = 3'd4; cmd_bit = 5'd4; cmd_kind = KIND_SA1; cmd_delay = 8'd0; cmd_duration = 8'd0;
      cmd_valid = 1'b1;
      @(negedge clk);
      check("both_ready", MW'(cmd_ready), MW'(0));
      @(posedge clk); #1;
      clear_all = 1'b0; cmd_valid = 1'b0;
      @(negedge clk);
      check("both_ready_back", MW'(cmd_ready), MW'(1));
      cycle(3);
      check("both_set", set_mask, '0);
      check("both_inj", MW'(inj_count), MW'(4));

      // Reset in WAIT with tick low discards the command.
      tick = 1'b0;
      send(3'd1, 5'd1, KIND_SA1, 8'd5, 8'd0);
      cycle(2);
      reset = 1'b1;
      cycle(2);
      reset = 1'b0;
      m_inj = 8'd0;
      @(negedge clk);
      check("wrst_set", set_mask, '0);
      check("wrst_ready", MW'(cmd_ready), MW'(1));
      check("wrst_inj", MW'(inj_count), MW'(0));
      tick = 1'b1;
      cycle(12);
      check("wrst_stays_clear", set_mask, '0);

      // 300 permanent commands saturate inj_count at 255.
      for (int n = 1; n <= 300; n++) begin
         m_set[(n % LANES)*WIDTH + (n % WIDTH)] = 1'b1;
         m_inj = (n > 255) ? 8'd255 : 8'(n);
         expect_event(1'b1);
         send(3'(n % LANES), 5'(n % WIDTH), KIND_SA1, 8'd0, 8'd0);
      end
      drain("sat_drain");
      check("inj_sat", MW'(inj_count), MW'(255));
      check("sat_set", set_mask, m_set);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
